// File: rtl/ooo_scoreboard_pkg.sv
// Shared types and default configuration for the out-of-order register/FU scoreboard.
package ooo_scoreboard_pkg;

  // Default configuration of the core this scoreboard was written for.
  localparam int NUM_REGS_DEF  = 32;
  localparam int NUM_FU_DEF    = 4;
  localparam int FU_DEPTH_DEF  = 2;
  localparam int NUM_WB_DEF    = 2;
  localparam int ROB_DEPTH_DEF = 8;

  localparam int REG_W = $clog2(NUM_REGS_DEF);
  localparam int FU_W  = $clog2(NUM_FU_DEF);
  localparam int TAG_W = $clog2(ROB_DEPTH_DEF);

  // One tracked architectural register: pending flag plus the ROB tag of its youngest producer.
  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } scoreboard_entry_t;

  // FU index order matches the scalar core's FU numbering.
  typedef enum logic [FU_W-1:0] {
    FU_AU = 2'd0,
    FU_MU = 2'd1,
    FU_DU = 2'd2,
    FU_LS = 2'd3
  } fu_idx_t;

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ooo_scoreboard_if.sv
// Decode / writeback / FU-retire bus between the front end and the scoreboard.
interface ooo_scoreboard_if #(
  parameter int NUM_REGS  = 32,
  parameter int NUM_FU    = 4,
  parameter int NUM_WB    = 2,
  parameter int ROB_DEPTH = 8
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int FU_W  = $clog2(NUM_FU);
  localparam int TAG_W = $clog2(ROB_DEPTH);

  // Issue request from decode
  logic                         issue_valid;
  logic                         issue_wen;
  logic [REG_W-1:0]             issue_rd;
  logic [REG_W-1:0]             issue_rs1;
  logic [REG_W-1:0]             issue_rs2;
  logic                         issue_use_rs1;
  logic                         issue_use_rs2;
  logic [FU_W-1:0]              issue_fu;
  logic [TAG_W-1:0]             issue_tag;
  logic                         rob_full;
  logic                         flush;

  // Writeback and FU retire
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB-1:0][REG_W-1:0] wb_rd;
  logic [NUM_WB-1:0][TAG_W-1:0] wb_tag;
  logic [NUM_FU-1:0]            fu_done;

  // Scoreboard responses
  logic                         rs1_busy;
  logic                         rs2_busy;
  logic [TAG_W-1:0]             rs1_tag;
  logic [TAG_W-1:0]             rs2_tag;
  logic                         rd_busy;
  logic [NUM_FU-1:0]            fu_busy;
  logic                         hazard;
  logic                         issue_ack;
  logic                         empty;

  modport master (
    output issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
           issue_use_rs1, issue_use_rs2, issue_fu, issue_tag, rob_full, flush,
           wb_valid, wb_rd, wb_tag, fu_done,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rd_busy, fu_busy,
           hazard, issue_ack, empty
  );

  modport slave (
    input  issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
           issue_use_rs1, issue_use_rs2, issue_fu, issue_tag, rob_full, flush,
           wb_valid, wb_rd, wb_tag, fu_done,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rd_busy, fu_busy,
           hazard, issue_ack, empty
  );

endinterface

// File: rtl/ooo_scoreboard_fu_occupancy_counter.sv
// Saturating up/down occupancy counter for one functional unit, with full/zero flags.
module ooo_scoreboard_fu_occupancy_counter #(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_reg;
  logic          inc_ok;
  logic          dec_ok;

  assign zero = (count_reg == '0);
  assign full = (count_reg == CW'(DEPTH));

  // A retire at zero is dropped; an issue at full only lands when a retire frees the slot.
  assign dec_ok = dec && !zero;
  assign inc_ok = inc && (!full || dec_ok);

  // Occupancy register: flush empties the unit, simultaneous inc/dec leaves it unchanged.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc_ok && !dec_ok) begin
      count_reg <= count_reg + CW'(1);
    end else if (dec_ok && !inc_ok) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  // Retiring from an empty unit means the FU and scoreboard have lost sync.
  a_no_underflow: assert property (@(posedge CLK) disable iff (!nRST) !(dec && zero && !clr));

  // The hazard path must keep an issue away from a full unit unless it retires the same cycle.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST) !(inc && full && !dec && !clr));

endmodule

// File: rtl/ooo_scoreboard.sv
// Register/FU scoreboard: tracks in-flight destinations by ROB tag and FU occupancy,
// and produces the decode-side hazard and producer tags for the two sources.
module ooo_scoreboard
  import ooo_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_FU    = NUM_FU_DEF,
  parameter int FU_DEPTH  = FU_DEPTH_DEF,
  parameter int NUM_WB    = NUM_WB_DEF,
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter bit STALL_WAW = 1'b0
) (
  input  logic              CLK,
  input  logic              nRST,
  ooo_scoreboard_if.slave   bus
);
  localparam int REG_BITS = $clog2(NUM_REGS);
  localparam int FU_BITS  = $clog2(NUM_FU);
  localparam int TAG_BITS = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic                busy;
    logic [TAG_BITS-1:0] tag;
  } entry_t;

  entry_t              sb_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] wb_clear;
  logic [NUM_REGS-1:0] pending;

  logic [NUM_FU-1:0]   fu_full;
  logic [NUM_FU-1:0]   fu_zero;
  logic [NUM_FU-1:0]   fu_blocked;
  logic [NUM_FU-1:0]   fu_inc;

  logic                rs1_busy;
  logic                rs2_busy;
  logic                rd_busy;
  logic                hazard;
  logic                issue_ack;
  logic                issue_write;

  // A register is cleared when any writeback port presents its current producer tag;
  // a writeback carrying an older tag (overwritten by a later issue) is ignored.
  always_comb begin
    wb_clear = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (bus.wb_valid[i] && (int'(bus.wb_rd[i]) == r) &&
            (bus.wb_tag[i] == sb_reg[r].tag)) begin
          wb_clear[r] = 1'b1;
        end
      end
    end
  end

  // Source lookups with same-cycle writeback bypass, and the stall decision.
  always_comb begin
    rs1_busy    = bus.issue_use_rs1 && pending[bus.issue_rs1];
    rs2_busy    = bus.issue_use_rs2 && pending[bus.issue_rs2];
    rd_busy     = pending[bus.issue_rd];
    hazard      = bus.flush || bus.rob_full || rs1_busy || rs2_busy ||
                  fu_blocked[bus.issue_fu] ||
                  (STALL_WAW && bus.issue_wen && rd_busy);
    issue_ack   = bus.issue_valid && !hazard;
    issue_write = issue_ack && bus.issue_wen && (bus.issue_rd != '0);
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign busy_vec[gi] = sb_reg[gi].busy;
    assign pending[gi]  = sb_reg[gi].busy && !wb_clear[gi];

    // Per-register state: flush clears, a new issue beats a same-cycle writeback,
    // otherwise a matching writeback retires the producer. x0 is never written.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        sb_reg[gi] <= '0;
      end else if (bus.flush) begin
        sb_reg[gi].busy <= 1'b0;
      end else if (issue_write && (bus.issue_rd == REG_BITS'(gi))) begin
        sb_reg[gi].busy <= 1'b1;
        sb_reg[gi].tag  <= bus.issue_tag;
      end else if (wb_clear[gi]) begin
        sb_reg[gi].busy <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    assign fu_inc[gi] = issue_ack && (bus.issue_fu == FU_BITS'(gi));
    // A full unit that retires this cycle can accept a new op in the same cycle.
    assign fu_blocked[gi] = fu_full[gi] && !bus.fu_done[gi];

    ooo_scoreboard_fu_occupancy_counter #(
      .DEPTH (FU_DEPTH)
    ) u_occ (
      .CLK  (CLK),
      .nRST (nRST),
      .clr  (bus.flush),
      .inc  (fu_inc[gi]),
      .dec  (bus.fu_done[gi]),
      .full (fu_full[gi]),
      .zero (fu_zero[gi])
    );
  end

  assign bus.rs1_busy  = rs1_busy;
  assign bus.rs2_busy  = rs2_busy;
  assign bus.rs1_tag   = sb_reg[bus.issue_rs1].tag;
  assign bus.rs2_tag   = sb_reg[bus.issue_rs2].tag;
  assign bus.rd_busy   = rd_busy;
  assign bus.fu_busy   = fu_blocked;
  assign bus.hazard    = hazard;
  assign bus.issue_ack = issue_ack;
  assign bus.empty     = (busy_vec == '0) && (&fu_zero);

endmodule

// File: tb/tb_ooo_scoreboard.sv
// Bench for ooo_scoreboard: two instances (rename-by-tag and WAW-stall) driven with the same
// directed stimulus, checked every cycle against a queue/array model plus literal expectations.
`timescale 1ns/1ps
module tb_ooo_scoreboard;
  import ooo_scoreboard_pkg::*;

  localparam int NR = 32;
  localparam int NF = 4;
  localparam int NW = 2;
  localparam int RB = 8;
  localparam int FD = 2;
  localparam int RW = 5;
  localparam int FW = 2;
  localparam int TW = 3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Shared stimulus
  logic                   issue_valid, issue_wen, use1, use2, rob_full, flush;
  logic [RW-1:0]          rd, rs1, rs2;
  logic [FW-1:0]          fu;
  logic [TW-1:0]          tag;
  logic [NW-1:0]          wb_valid;
  logic [NW-1:0][RW-1:0]  wb_rd;
  logic [NW-1:0][TW-1:0]  wb_tag;
  logic [NF-1:0]          fu_done;

  ooo_scoreboard_if #(.NUM_REGS(NR), .NUM_FU(NF), .NUM_WB(NW), .ROB_DEPTH(RB)) bus0 ();
  ooo_scoreboard_if #(.NUM_REGS(NR), .NUM_FU(NF), .NUM_WB(NW), .ROB_DEPTH(RB)) bus1 ();

  assign bus0.issue_valid = issue_valid;   assign bus1.issue_valid = issue_valid;
  assign bus0.issue_wen = issue_wen;       assign bus1.issue_wen = issue_wen;
  assign bus0.issue_rd = rd;               assign bus1.issue_rd = rd;
  assign bus0.issue_rs1 = rs1;             assign bus1.issue_rs1 = rs1;
  assign bus0.issue_rs2 = rs2;             assign bus1.issue_rs2 = rs2;
  assign bus0.issue_use_rs1 = use1;        assign bus1.issue_use_rs1 = use1;
  assign bus0.issue_use_rs2 = use2;        assign bus1.issue_use_rs2 = use2;
  assign bus0.issue_fu = fu;               assign bus1.issue_fu = fu;
  assign bus0.issue_tag = tag;             assign bus1.issue_tag = tag;
  assign bus0.rob_full = rob_full;         assign bus1.rob_full = rob_full;
  assign bus0.flush = flush;               assign bus1.flush = flush;
  assign bus0.wb_valid = wb_valid;         assign bus1.wb_valid = wb_valid;
  assign bus0.wb_rd = wb_rd;               assign bus1.wb_rd = wb_rd;
  assign bus0.wb_tag = wb_tag;             assign bus1.wb_tag = wb_tag;
  assign bus0.fu_done = fu_done;           assign bus1.fu_done = fu_done;

  ooo_scoreboard #(.NUM_REGS(NR), .NUM_FU(NF), .FU_DEPTH(FD), .NUM_WB(NW),
                   .ROB_DEPTH(RB), .STALL_WAW(1'b0)) dut0 (.CLK(CLK), .nRST(nRST), .bus(bus0));
  ooo_scoreboard #(.NUM_REGS(NR), .NUM_FU(NF), .FU_DEPTH(FD), .NUM_WB(NW),
                   .ROB_DEPTH(RB), .STALL_WAW(1'b1)) dut1 (.CLK(CLK), .nRST(nRST), .bus(bus1));

  // DUT outputs gathered per instance
  logic          o_rs1b [2], o_rs2b [2], o_rdb [2], o_haz [2], o_ack [2], o_empty [2];
  logic [TW-1:0] o_rs1t [2], o_rs2t [2];
  logic [NF-1:0] o_fub [2];
  assign o_rs1b[0] = bus0.rs1_busy;   assign o_rs1b[1] = bus1.rs1_busy;
  assign o_rs2b[0] = bus0.rs2_busy;   assign o_rs2b[1] = bus1.rs2_busy;
  assign o_rdb[0]  = bus0.rd_busy;    assign o_rdb[1]  = bus1.rd_busy;
  assign o_haz[0]  = bus0.hazard;     assign o_haz[1]  = bus1.hazard;
  assign o_ack[0]  = bus0.issue_ack;  assign o_ack[1]  = bus1.issue_ack;
  assign o_empty[0] = bus0.empty;     assign o_empty[1] = bus1.empty;
  assign o_rs1t[0] = bus0.rs1_tag;    assign o_rs1t[1] = bus1.rs1_tag;
  assign o_rs2t[0] = bus0.rs2_tag;    assign o_rs2t[1] = bus1.rs2_tag;
  assign o_fub[0]  = bus0.fu_busy;    assign o_fub[1]  = bus1.fu_busy;

  // ---------------- behavioural model (instance k: k==1 stalls on WAW) ----------------
  logic          m_busy [2][NR];
  logic [TW-1:0] m_tag  [2][NR];
  int            m_cnt  [2][NF];

  function automatic logic m_wb_hit(input int k, input int r);
    for (int i = 0; i < NW; i++)
      if (wb_valid[i] && int'(wb_rd[i]) == r && wb_tag[i] == m_tag[k][r]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_pending(input int k, input int r);
    if (r == 0 || !m_busy[k][r]) return 1'b0;
    return !m_wb_hit(k, r);
  endfunction

  function automatic logic m_fu_blocked(input int k, input int f);
    return (m_cnt[k][f] == FD) && !fu_done[f];
  endfunction

  function automatic logic m_hazard(input int k);
    return flush || rob_full ||
           (use1 && m_pending(k, int'(rs1))) || (use2 && m_pending(k, int'(rs2))) ||
           m_fu_blocked(k, int'(fu)) ||
           (k == 1 && issue_wen && m_pending(k, int'(rd)));
  endfunction

  function automatic logic m_ack(input int k);
    return issue_valid && !m_hazard(k);
  endfunction

  function automatic logic m_empty(input int k);
    for (int r = 0; r < NR; r++) if (m_busy[k][r]) return 1'b0;
    for (int f = 0; f < NF; f++) if (m_cnt[k][f] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Model state advance
  always @(posedge CLK or negedge nRST) begin
    for (int k = 0; k < 2; k++) begin
      if (!nRST || flush) begin
        for (int r = 0; r < NR; r++) m_busy[k][r] <= 1'b0;
        for (int f = 0; f < NF; f++) m_cnt[k][f] <= 0;
        if (!nRST) for (int r = 0; r < NR; r++) m_tag[k][r] <= '0;
      end else begin
        for (int r = 1; r < NR; r++) begin
          if (m_ack(k) && issue_wen && int'(rd) == r) begin
            m_busy[k][r] <= 1'b1;
            m_tag[k][r]  <= tag;
          end else if (m_wb_hit(k, r)) begin
            m_busy[k][r] <= 1'b0;
          end
        end
        for (int f = 0; f < NF; f++)
          m_cnt[k][f] <= m_cnt[k][f] + ((m_ack(k) && int'(fu) == f) ? 1 : 0)
                                     - ((fu_done[f] && m_cnt[k][f] > 0) ? 1 : 0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      logic e_rs1b, e_rs2b;
      e_rs1b = use1 && m_pending(k, int'(rs1));
      e_rs2b = use2 && m_pending(k, int'(rs2));
      chk($sformatf("dut%0d rs1_busy", k), 32'(o_rs1b[k]), 32'(e_rs1b));
      chk($sformatf("dut%0d rs2_busy", k), 32'(o_rs2b[k]), 32'(e_rs2b));
      if (e_rs1b) chk($sformatf("dut%0d rs1_tag", k), 32'(o_rs1t[k]), 32'(m_tag[k][rs1]));
      if (e_rs2b) chk($sformatf("dut%0d rs2_tag", k), 32'(o_rs2t[k]), 32'(m_tag[k][rs2]));
      chk($sformatf("dut%0d rd_busy", k), 32'(o_rdb[k]), 32'(m_pending(k, int'(rd))));
      for (int f = 0; f < NF; f++)
        chk($sformatf("dut%0d fu_busy[%0d]", k, f), 32'(o_fub[k][f]), 32'(m_fu_blocked(k, f)));
      chk($sformatf("dut%0d hazard", k), 32'(o_haz[k]), 32'(m_hazard(k)));
      chk($sformatf("dut%0d issue_ack", k), 32'(o_ack[k]), 32'(m_ack(k)));
      chk($sformatf("dut%0d empty", k), 32'(o_empty[k]), 32'(m_empty(k)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    issue_valid = 0; issue_wen = 0; use1 = 0; use2 = 0; rob_full = 0; flush = 0;
    rd = '0; rs1 = '0; rs2 = '0; fu = '0; tag = '0;
    wb_valid = '0; wb_rd = '0; wb_tag = '0; fu_done = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic iss(input int r, input int s1, input bit u1, input int s2, input bit u2,
                     input int f, input int t);
    issue_valid = 1; issue_wen = 1;
    rd = RW'(r); rs1 = RW'(s1); use1 = u1; rs2 = RW'(s2); use2 = u2;
    fu = FW'(f); tag = TW'(t);
  endtask

  task automatic wb(input int p, input int r, input int t);
    wb_valid[p] = 1'b1;
    wb_rd[p]    = RW'(r);
    wb_tag[p]   = TW'(t);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1; rs1 = 5; use1 = 1; #2;
    chk("rst empty", 32'(bus0.empty), 1);
    chk("rst fu_busy", 32'(bus0.fu_busy), 0);
    chk("rst rs1_busy", 32'(bus0.rs1_busy), 0);
    chk("rst hazard", 32'(bus0.hazard), 0);
    nRST = 1;

    step(); iss(5, 0, 0, 0, 0, int'(FU_AU), 3); #2;
    chk("T1 ack", 32'(bus0.issue_ack), 1);
    step(); rs1 = 5; use1 = 1; rs2 = 5; use2 = 0; fu_done = 4'b0001; #2;
    chk("T2 rs1_busy", 32'(bus0.rs1_busy), 1);
    chk("T2 rs1_tag", 32'(bus0.rs1_tag), 3);
    chk("T2 rs2_busy gated", 32'(bus0.rs2_busy), 0);
    chk("T2 empty", 32'(bus0.empty), 0);
    step(); iss(6, 5, 1, 0, 0, int'(FU_AU), 4); wb(0, 5, 3); #2;
    chk("T3 bypass rs1_busy", 32'(bus0.rs1_busy), 0);
    chk("T3 bypass ack", 32'(bus0.issue_ack), 1);
    step(); rs1 = 5; use1 = 1; fu_done = 4'b0001; wb(0, 6, 4); #2;
    chk("T4 x5 clear", 32'(bus0.rs1_busy), 0);
    step(); iss(5, 0, 0, 0, 0, int'(FU_DU), 3); #2;
    chk("T5 empty", 32'(bus0.empty), 1);
    chk("T5 ack", 32'(bus0.issue_ack), 1);
    step(); iss(5, 0, 0, 0, 0, int'(FU_DU), 4); #2;
    chk("T6 rd_busy", 32'(bus0.rd_busy), 1);
    chk("T6 waw0 ack", 32'(bus0.issue_ack), 1);
    chk("T6 waw1 hazard", 32'(bus1.hazard), 1);
    chk("T6 waw1 ack", 32'(bus1.issue_ack), 0);
    step(); rs1 = 5; use1 = 1; rs2 = 5; use2 = 1; wb(0, 5, 3); fu_done = 4'b0100; #2;
    chk("T7 stale wb rs1_busy", 32'(bus0.rs1_busy), 1);
    chk("T7 stale wb rs1_tag", 32'(bus0.rs1_tag), 4);
    chk("T7 rs2_busy", 32'(bus0.rs2_busy), 1);
    chk("T7 waw1 wb clears", 32'(bus1.rs1_busy), 0);
    step(); rs1 = 5; use1 = 1; #2;
    chk("T8 rs1_busy", 32'(bus0.rs1_busy), 1);
    chk("T8 rs1_tag", 32'(bus0.rs1_tag), 4);
    step(); rs1 = 5; use1 = 1; wb(1, 5, 4); #2;
    chk("T9 port1 bypass", 32'(bus0.rs1_busy), 0);
    step(); iss(7, 5, 1, 0, 0, int'(FU_MU), 1); #2;
    chk("T10 rs1_busy", 32'(bus0.rs1_busy), 0);
    chk("T10 ack", 32'(bus0.issue_ack), 1);
    step(); iss(8, 0, 0, 0, 0, int'(FU_MU), 2); #2;
    chk("T11 ack", 32'(bus0.issue_ack), 1);
    step(); iss(9, 0, 0, 0, 0, int'(FU_MU), 5); #2;
    chk("T12 fu_busy", 32'(bus0.fu_busy), 32'h2);
    chk("T12 hazard", 32'(bus0.hazard), 1);
    chk("T12 ack", 32'(bus0.issue_ack), 0);
    step(); iss(9, 0, 0, 0, 0, int'(FU_MU), 5); fu_done = 4'b0010; #2;
    chk("T13 ack with done", 32'(bus0.issue_ack), 1);
    chk("T13 fu_busy", 32'(bus0.fu_busy), 0);
    step(); iss(10, 0, 0, 0, 0, int'(FU_AU), 6); #2;
    chk("T14 fu1 stays full", 32'(bus0.fu_busy), 32'h2);
    step(); iss(11, 0, 0, 0, 0, int'(FU_LS), 7);
    step(); iss(12, 0, 0, 0, 0, int'(FU_AU), 0);
    step(); iss(13, 0, 0, 0, 0, int'(FU_DU), 1); flush = 1; wb(0, 7, 1); fu_done = 4'b1000; #2;
    chk("T17 flush ack", 32'(bus0.issue_ack), 0);
    chk("T17 flush hazard", 32'(bus0.hazard), 1);
    chk("T17 not empty", 32'(bus0.empty), 0);
    step(); rs1 = 9; use1 = 1; rd = 12; #2;
    chk("T18 empty0", 32'(bus0.empty), 1);
    chk("T18 empty1", 32'(bus1.empty), 1);
    chk("T18 fu_busy", 32'(bus0.fu_busy), 0);
    chk("T18 rs1_busy", 32'(bus0.rs1_busy), 0);
    chk("T18 rd_busy", 32'(bus0.rd_busy), 0);
    step(); iss(5, 1, 1, 0, 0, int'(FU_AU), 2); rob_full = 1; #2;
    chk("T19 rob_full hazard", 32'(bus0.hazard), 1);
    chk("T19 rob_full ack", 32'(bus0.issue_ack), 0);
    step(); rd = 5; #2;
    chk("T20 rd_busy", 32'(bus0.rd_busy), 0);
    chk("T20 empty", 32'(bus0.empty), 1);
    step(); iss(3, 0, 0, 0, 0, int'(FU_AU), 1); #2;
    chk("T21 ack", 32'(bus0.issue_ack), 1);
    step(); rd = 3; #2;
    chk("T22 rd_busy", 32'(bus0.rd_busy), 1);
    nRST = 0; #1;
    chk("T22 async reset empty", 32'(bus0.empty), 1);
    chk("T22 async reset rd_busy", 32'(bus0.rd_busy), 0);
    step(); nRST = 1; iss(0, 0, 0, 0, 0, int'(FU_AU), 2); #2;
    chk("T23 x0 ack", 32'(bus0.issue_ack), 1);
    step(); rs1 = 0; use1 = 1; rd = 0; #2;
    chk("T24 x0 rs1_busy", 32'(bus0.rs1_busy), 0);
    chk("T24 x0 rd_busy", 32'(bus0.rd_busy), 0);
    chk("T24 fu count", 32'(bus0.empty), 0);
    step(); fu_done = 4'b0001;
    step(); #2;
    chk("T26 empty", 32'(bus0.empty), 1);
    step();
    @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
